// File: rtl/arbiter_n_to_1_request.sv
// Round-robin N-to-1 request concentrator. Registered one-hot grants pop the
// requestors; winners pass through a write stage into a FWFT output FIFO.
module arbiter_n_to_1_request #(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int FIFO_WRITE_DEPTH     = 32,
  parameter int PROG_THRESH          = 16,
  parameter int PAYLOAD_WIDTH        = 32
) (
  input  logic                                            ap_clk,
  input  logic                                            areset,
  input  logic [NUM_MEMORY_REQUESTOR-1:0]                 request_in_valid,
  input  logic [NUM_MEMORY_REQUESTOR*PAYLOAD_WIDTH-1:0]   request_in_payload,
  input  logic                                            fifo_request_signals_in_rd_en,
  output logic [NUM_MEMORY_REQUESTOR-1:0]                 arbiter_grant_out,
  output logic                                            request_out_valid,
  output logic [PAYLOAD_WIDTH-1:0]                        request_out_payload,
  output logic                                            fifo_request_signals_out_full,
  output logic                                            fifo_request_signals_out_empty,
  output logic                                            fifo_request_signals_out_prog_full,
  output logic                                            fifo_setup_signal
);
  // Handshake: request_in_valid[i] holds with its payload until arbiter_grant_out[i]
  // is seen high; that grant cycle is the pop, and a new packet may follow next cycle.
  localparam int N     = NUM_MEMORY_REQUESTOR;
  localparam int PTR_W = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic                     areset_ctl;
  logic                     rd_en_reg;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         rr_next;
  logic [PTR_W-1:0]         win_idx;
  logic [N-1:0]             elig;
  logic [N-1:0]             mask_hi;
  logic [N-1:0]             elig_hi;
  logic [N-1:0]             pick_src;
  logic [N-1:0]             win_oh;
  logic [PAYLOAD_WIDTH-1:0] win_payload;
  logic                     arb_en;
  logic                     wr_valid;
  logic [PAYLOAD_WIDTH-1:0] wr_payload;
  logic [PAYLOAD_WIDTH-1:0] fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_prog_full;
  logic                     fifo_valid;
  logic                     wr_rst_busy;
  logic                     rd_rst_busy;
  logic                     pop;

  always_ff @(posedge ap_clk) areset_ctl <= areset;

  assign arb_en = areset_ctl & ~fifo_setup_signal & ~fifo_request_signals_out_prog_full;

  // The stale packet shown during its own grant cycle must not win again.
  assign elig     = request_in_valid & ~arbiter_grant_out & {N{arb_en}};
  assign mask_hi  = ~((ONE << rr_ptr) - ONE);
  assign elig_hi  = elig & mask_hi;
  assign pick_src = (|elig_hi) ? elig_hi : elig;
  assign win_oh   = pick_src & (~pick_src + ONE);

  always_comb begin
    win_idx     = '0;
    win_payload = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        win_idx     = PTR_W'(i);
        win_payload = request_in_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
  end

  assign rr_next = (win_idx == PTR_W'(N-1)) ? '0 : win_idx + PTR_W'(1);

  always_ff @(posedge ap_clk) begin
    if (!areset_ctl) begin
      arbiter_grant_out <= '0;
      wr_valid          <= 1'b0;
      rr_ptr            <= '0;
    end else begin
      arbiter_grant_out <= win_oh;
      wr_valid          <= |win_oh;
      if (|win_oh) rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (|win_oh) wr_payload <= win_payload;
  end

  assign pop = ~fifo_empty & rd_en_reg & fifo_valid;

  always_ff @(posedge ap_clk) begin
    if (!areset_ctl) begin
      rd_en_reg         <= 1'b0;
      request_out_valid <= 1'b0;
      fifo_setup_signal <= 1'b1;
    end else begin
      rd_en_reg         <= fifo_request_signals_in_rd_en;
      request_out_valid <= pop;
      fifo_setup_signal <= wr_rst_busy | rd_rst_busy;
    end
  end

  // Status copies and output payload are deliberately unreset.
  always_ff @(posedge ap_clk) begin
    request_out_payload                <= fifo_dout;
    fifo_request_signals_out_full      <= fifo_full;
    fifo_request_signals_out_empty     <= fifo_empty;
    fifo_request_signals_out_prog_full <= fifo_prog_full;
  end

  xpm_fifo_sync_wrapper #(
    .DEPTH       (FIFO_WRITE_DEPTH),
    .WIDTH       (PAYLOAD_WIDTH),
    .PROG_THRESH (PROG_THRESH)
  ) u_fifo (
    .clk         (ap_clk),
    .srst        (~areset_ctl),
    .wr_en       (wr_valid),
    .din         (wr_payload),
    .rd_en       (pop),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .prog_full   (fifo_prog_full),
    .valid       (fifo_valid),
    .wr_rst_busy (wr_rst_busy),
    .rd_rst_busy (rd_rst_busy)
  );
endmodule

// Synchronous FWFT FIFO: dout shows the head entry whenever valid is high.
// Reset-busy stays high during srst and for two cycles after it releases.
module xpm_fifo_sync_wrapper #(
  parameter int DEPTH       = 32,
  parameter int WIDTH       = 32,
  parameter int PROG_THRESH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             prog_full,
  output logic             valid,
  output logic             wr_rst_busy,
  output logic             rd_rst_busy
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [1:0]        busy_cnt;
  logic              busy;
  logic              do_wr;
  logic              do_rd;

  assign busy        = srst | (busy_cnt != 2'd0);
  assign wr_rst_busy = busy;
  assign rd_rst_busy = busy;
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign prog_full   = (count >= CNT_W'(PROG_THRESH));
  assign valid       = ~empty & ~busy;
  assign dout        = mem[rd_ptr];
  assign do_wr       = wr_en & ~full & ~busy;
  assign do_rd       = rd_en & ~empty & ~busy;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      busy_cnt <= 2'd2;
    end else begin
      if (busy_cnt != 2'd0) busy_cnt <= busy_cnt - 2'd1;
      if (do_wr) wr_ptr <= (wr_ptr == ADDR_W'(DEPTH-1)) ? '0 : wr_ptr + ADDR_W'(1);
      if (do_rd) rd_ptr <= (rd_ptr == ADDR_W'(DEPTH-1)) ? '0 : rd_ptr + ADDR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end
endmodule

// File: tb/tb_arbiter_n_to_1_request.sv
// Bench for the round-robin request concentrator: transaction-level model of
// arbitration and the output queue, plus directed scenarios with literal checks.
module tb_arbiter_n_to_1_request;
  localparam int N      = 4;
  localparam int W      = 32;
  localparam int DEPTH  = 32;
  localparam int THRESH = 16;
  localparam int QMAX   = 64;

  logic           ap_clk = 1'b0;
  logic           areset;
  logic [N-1:0]   request_in_valid;
  logic [N*W-1:0] request_in_payload;
  logic           fifo_request_signals_in_rd_en;
  logic [N-1:0]   arbiter_grant_out;
  logic           request_out_valid;
  logic [W-1:0]   request_out_payload;
  logic           fifo_request_signals_out_full;
  logic           fifo_request_signals_out_empty;
  logic           fifo_request_signals_out_prog_full;
  logic           fifo_setup_signal;

  arbiter_n_to_1_request #(
    .NUM_MEMORY_REQUESTOR (N),
    .FIFO_WRITE_DEPTH     (DEPTH),
    .PROG_THRESH          (THRESH),
    .PAYLOAD_WIDTH        (W)
  ) dut (
    .ap_clk                             (ap_clk),
    .areset                             (areset),
    .request_in_valid                   (request_in_valid),
    .request_in_payload                 (request_in_payload),
    .fifo_request_signals_in_rd_en      (fifo_request_signals_in_rd_en),
    .arbiter_grant_out                  (arbiter_grant_out),
    .request_out_valid                  (request_out_valid),
    .request_out_payload                (request_out_payload),
    .fifo_request_signals_out_full      (fifo_request_signals_out_full),
    .fifo_request_signals_out_empty     (fifo_request_signals_out_empty),
    .fifo_request_signals_out_prog_full (fifo_request_signals_out_prog_full),
    .fifo_setup_signal                  (fifo_setup_signal)
  );

  // ---------------- clock ----------------
  always #5 ap_clk = ~ap_clk;

  // ---------------- bench state ----------------
  logic         areset_ctrl;
  logic         rd_en_ctrl;
  logic [W-1:0] req_mem [N][QMAX];
  int           req_head [N];
  int           req_tail [N];

  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_grant;
  logic         m_wv;
  logic [W-1:0] m_wd;
  int           m_rr;
  logic         m_rdprev;
  logic [3:0]   hist;
  logic         m_out_v;
  logic [W-1:0] m_out_d;
  logic         m_full_r;
  logic         m_empty_r;
  logic         m_pf_r;

  int           checks;
  int           errors;
  int           cyc;
  bit           chk_en;
  int           ph_grants;
  int           ph_outs;
  logic [N-1:0] grant_log[$];
  int           grant_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #2;
  endtask

  task automatic push(input int i, input logic [W-1:0] tag);
    req_mem[i][req_tail[i]] = tag;
    req_tail[i]++;
  endtask

  task automatic clear_phase();
    ph_grants = 0;
    ph_outs   = 0;
    grant_log.delete();
    grant_cyc.delete();
  endtask

  // ---------------- per-cycle compare, requestor driver and model ----------------
  always @(negedge ap_clk) begin
    logic [N-1:0] new_grant;
    int           sz;
    int           idx;
    bit           found;
    bit           en;
    bit           pop;
    logic         nxt_full, nxt_empty, nxt_pf;

    cyc++;
    if (chk_en) begin
      check("grant", 32'(arbiter_grant_out), 32'(m_grant));
      check("out_valid", 32'(request_out_valid), 32'(m_out_v));
      if (m_out_v) check("out_payload", request_out_payload, m_out_d);
      check("setup", 32'(fifo_setup_signal), 32'(!(hist[1] && hist[2] && hist[3])));
      check("full_r", 32'(fifo_request_signals_out_full), 32'(m_full_r));
      check("empty_r", 32'(fifo_request_signals_out_empty), 32'(m_empty_r));
      check("prog_full_r", 32'(fifo_request_signals_out_prog_full), 32'(m_pf_r));
    end
    if (arbiter_grant_out != '0) begin
      ph_grants++;
      grant_log.push_back(arbiter_grant_out);
      grant_cyc.push_back(cyc);
    end
    if (request_out_valid) ph_outs++;

    // Requestors pop on the cycle their grant is visible.
    for (int i = 0; i < N; i++)
      if (m_grant[i] && req_head[i] < req_tail[i]) req_head[i]++;

    areset = areset_ctrl;
    fifo_request_signals_in_rd_en = rd_en_ctrl;
    for (int i = 0; i < N; i++) begin
      request_in_valid[i] = (req_head[i] < req_tail[i]);
      request_in_payload[i*W +: W] = (req_head[i] < req_tail[i]) ? req_mem[i][req_head[i]] : '0;
    end

    // Model: values for the next cycle from this cycle's state and inputs.
    sz        = exp_q.size();
    nxt_full  = (sz == DEPTH);
    nxt_empty = (sz == 0);
    nxt_pf    = (sz >= THRESH);
    if (!hist[0]) begin
      exp_q.delete();
      m_wv     = 1'b0;
      m_grant  = '0;
      m_rr     = 0;
      m_rdprev = 1'b0;
      m_out_v  = 1'b0;
    end else begin
      en  = (hist == 4'hF) && !m_pf_r;
      pop = (sz > 0) && m_rdprev;
      m_out_v = pop;
      if (pop) m_out_d = exp_q.pop_front();
      if (m_wv) begin
        if (exp_q.size() >= DEPTH) check("overflow", 32'(exp_q.size()), 32'(DEPTH - 1));
        exp_q.push_back(m_wd);
      end
      new_grant = '0;
      m_wv      = 1'b0;
      found     = 1'b0;
      if (en) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (!found && request_in_valid[idx] && !m_grant[idx]) begin
            found          = 1'b1;
            new_grant[idx] = 1'b1;
            m_wv           = 1'b1;
            m_wd           = req_mem[idx][req_head[idx]];
          end
        end
        if (found) begin
          for (int k = 0; k < N; k++)
            if (new_grant[k]) m_rr = (k + 1) % N;
        end
      end
      m_grant  = new_grant;
      m_rdprev = rd_en_ctrl;
    end
    m_full_r  = nxt_full;
    m_empty_r = nxt_empty;
    m_pf_r    = nxt_pf;
    hist      = {hist[2:0], areset_ctrl};
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [N-1:0] rr_exp [8];
    logic [N-1:0] wrap_exp [4];
    int           setup_ticks;

    checks = 0; errors = 0; cyc = 0; chk_en = 1'b0;
    areset = 1'b0; areset_ctrl = 1'b0; rd_en_ctrl = 1'b0;
    fifo_request_signals_in_rd_en = 1'b0;
    request_in_valid = '0; request_in_payload = '0;
    for (int i = 0; i < N; i++) begin req_head[i] = 0; req_tail[i] = 0; end
    m_grant = '0; m_wv = 1'b0; m_wd = '0; m_rr = 0; m_rdprev = 1'b0; hist = 4'h0;
    m_out_v = 1'b0; m_out_d = '0; m_full_r = 1'b0; m_empty_r = 1'b1; m_pf_r = 1'b0;
    clear_phase();

    // Reset: requests already pending must not be granted before setup clears.
    tick(3);
    chk_en = 1'b1;
    rd_en_ctrl = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < N; i++) push(i, 32'h100 + 32'(i * 16 + s));
    tick(1);
    check("rst_grant", 32'(arbiter_grant_out), 32'h0);
    check("rst_out_valid", 32'(request_out_valid), 32'h0);
    check("rst_setup", 32'(fifo_setup_signal), 32'h1);
    areset_ctrl = 1'b1;
    setup_ticks = 0;
    while (fifo_setup_signal && setup_ticks < 20) begin
      tick(1);
      setup_ticks++;
    end
    check("setup_release_cycles", 32'(setup_ticks), 32'd4);
    check("no_grant_in_setup", 32'(ph_grants), 32'd0);

    // Round robin with all four requestors pending.
    tick(30);
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int k = 0; k < 8; k++)
      check("rr_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'h0, 32'(rr_exp[k]));
    check("rr_grants", 32'(ph_grants), 32'd16);
    check("rr_outs", 32'(ph_outs), 32'd16);

    // Single requestor: one grant every other cycle.
    clear_phase();
    for (int s = 0; s < 3; s++) push(2, 32'h200 + 32'(s));
    tick(15);
    check("single_grants", 32'(ph_grants), 32'd3);
    check("single_outs", 32'(ph_outs), 32'd3);
    for (int k = 1; k < 3; k++)
      check("single_gap", (k < grant_cyc.size()) ? 32'(grant_cyc[k] - grant_cyc[k-1]) : 32'h0, 32'd2);

    // Wrap: pointer sits at 3; late requestor 3 is served before 0's second packet.
    clear_phase();
    push(0, 32'h300); push(0, 32'h301); push(1, 32'h310);
    tick(1);
    push(3, 32'h330);
    tick(12);
    wrap_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    for (int k = 0; k < 4; k++)
      check("wrap_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'h0, 32'(wrap_exp[k]));
    check("wrap_outs", 32'(ph_outs), 32'd4);

    // Backpressure: grants stop at the threshold, then everything drains in order.
    clear_phase();
    rd_en_ctrl = 1'b0;
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < N; i++) push(i, 32'h400 + 32'(i * 16 + s));
    tick(40);
    check("bp_stall_grants", 32'(ph_grants), 32'd18);
    check("bp_model_depth", 32'(exp_q.size()), 32'd18);
    check("bp_prog_full", 32'(fifo_request_signals_out_prog_full), 32'h1);
    check("bp_no_outs", 32'(ph_outs), 32'd0);
    rd_en_ctrl = 1'b1;
    tick(80);
    check("bp_total_grants", 32'(ph_grants), 32'd32);
    check("bp_total_outs", 32'(ph_outs), 32'd32);

    // Mid-operation reset with ten buffered packets.
    clear_phase();
    rd_en_ctrl = 1'b0;
    for (int i = 0; i < N; i++) push(i, 32'h500 + 32'(i));
    for (int i = 0; i < N; i++) push(i, 32'h510 + 32'(i));
    push(0, 32'h520); push(1, 32'h521);
    tick(20);
    check("mr_grants", 32'(ph_grants), 32'd10);
    check("mr_model_depth", 32'(exp_q.size()), 32'd10);
    areset_ctrl = 1'b0;
    tick(5);
    check("mr_grant_zero", 32'(arbiter_grant_out), 32'h0);
    check("mr_out_zero", 32'(request_out_valid), 32'h0);
    areset_ctrl = 1'b1;
    rd_en_ctrl = 1'b1;
    clear_phase();
    tick(20);
    check("mr_no_stale", 32'(ph_outs), 32'd0);
    check("mr_empty", 32'(fifo_request_signals_out_empty), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
